csr_access_unit: RTL and testbench

//  Zicsr initiator for CSRFile: accepts one decoded CSR instruction, reads the CSR, computes RW/RS/RC result,

---
 rtl/csr_access_unit_pkg.sv | 34 +++
 rtl/csr_access_unit_rmw_alu.sv | 42 ++++
 rtl/csr_access_unit.sv | 156 +++++++++++++++
 tb/tb_csr_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 encodings, CSR addresses, FSM states.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  // funct3 000 (ECALL/EBREAK space) and 100 are not Zicsr operations
  function automatic logic is_illegal_funct3(input logic [2:0] funct3);
    return funct3[1:0] == 2'b00;
  endfunction

  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_unit_rmw_alu.sv
// Combinational read-modify-write datapath: new CSR value and whether a write-back is needed.
module csr_rmw_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_value,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      uimm,
  output logic [XLEN-1:0] new_value,
  output logic            need_write
);

  logic [XLEN-1:0] src;

  // Set/clear forms with rs1=x0 (or uimm=0) are pure reads and must not write
  always_comb begin
    src        = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_data;
    new_value  = old_value;
    need_write = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: begin
        new_value  = src;
        need_write = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        new_value  = old_value | src;
        need_write = (uimm != 5'd0);
      end
      F3_CSRRC, F3_CSRRCI: begin
        new_value  = old_value & ~src;
        need_write = (uimm != 5'd0);
      end
      default: begin
        new_value  = old_value;
        need_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: reads a CSR, applies RW/RS/RC, writes back, returns the old value.
// Optional macro CSR_ACCESS_RO_CHECK_EN rejects writes to read-only CSRs (addr[11:10]==2'b11).
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int READY_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [4:0]      req_rs1_idx,
  output logic [11:0]     csr_read_address,
  output logic [11:0]     csr_write_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic            csr_write_enable,
  input  logic [XLEN-1:0] csr_read_out,
  input  logic            csr_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rd_data,
  output logic            rsp_illegal
);

  localparam int CNT_W = $clog2(READY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READY_TIMEOUT - 1);

  state_t          state, state_next;
  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] rs1_q;
  logic [4:0]      idx_q;
  logic [XLEN-1:0] old_q;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic            we_q;
  logic [XLEN-1:0] alu_new;
  logic            need_write;
  logic            ro_block;
  logic [XLEN-1:0] rsp_data_next;
  logic            rsp_illegal_next;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .funct3    (funct3_q),
    .old_value (csr_read_out),
    .rs1_data  (rs1_q),
    .uimm      (idx_q),
    .new_value (alu_new),
    .need_write(need_write)
  );

`ifdef CSR_ACCESS_RO_CHECK_EN
  assign ro_block = need_write && is_read_only(addr_q);
`else
  assign ro_block = 1'b0;
`endif

  // A pipeline kill must suppress a write already registered for this cycle
  assign csr_write_enable = we_q & ~flush;

  always_comb begin
    state_next       = state;
    cnt_next         = '0;
    rsp_data_next    = '0;
    rsp_illegal_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_illegal_funct3(req_funct3)) begin
            state_next       = ST_RESP;
            rsp_illegal_next = 1'b1;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (csr_ready) begin
          if (ro_block) begin
            state_next       = ST_RESP;
            rsp_illegal_next = 1'b1;
          end else if (need_write) begin
            state_next = ST_WRITE;
          end else begin
            state_next    = ST_RESP;
            rsp_data_next = csr_read_out;
          end
        end else if (cnt == CNT_LAST) begin
          state_next       = ST_RESP;
          rsp_illegal_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_WRITE: begin
        state_next    = ST_RESP;
        rsp_data_next = old_q;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      req_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      we_q              <= 1'b0;
      rsp_rd_data       <= '0;
      rsp_illegal       <= 1'b0;
      csr_read_address  <= '0;
      csr_write_address <= '0;
      csr_write_data    <= '0;
      funct3_q          <= '0;
      addr_q            <= '0;
      rs1_q             <= '0;
      idx_q             <= '0;
      old_q             <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == ST_IDLE);
      rsp_valid <= (state_next == ST_RESP);
      we_q      <= (state_next == ST_WRITE);
      if (state == ST_IDLE && state_next != ST_IDLE) begin
        funct3_q <= req_funct3;
        addr_q   <= req_csr_addr;
        rs1_q    <= req_rs1_data;
        idx_q    <= req_rs1_idx;
      end
      if (state == ST_IDLE && state_next == ST_READ) begin
        csr_read_address <= req_csr_addr;
      end
      if (state == ST_READ && csr_ready) begin
        old_q <= csr_read_out;
      end
      if (state_next == ST_WRITE) begin
        csr_write_address <= addr_q;
        csr_write_data    <= alu_new;
      end
      if (state_next == ST_RESP) begin
        rsp_rd_data <= rsp_data_next;
        rsp_illegal <= rsp_illegal_next;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit with a CSR file model and a spec-level reference model.
// Expectations follow CSR_ACCESS_RO_CHECK_EN when it is defined for the build.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  localparam int XLEN          = 32;
  localparam int READY_TIMEOUT = 16;
  localparam int WAIT_LIMIT    = 60;
`ifdef CSR_ACCESS_RO_CHECK_EN
  localparam bit RO_CHECK = 1'b1;
`else
  localparam bit RO_CHECK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic [11:0] csr_read_address;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        csr_write_enable;
  logic [31:0] csr_read_out;
  logic        csr_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rd_data;
  logic        rsp_illegal;

  int errors = 0;
  int checks = 0;

  csr_access_unit #(.XLEN(XLEN), .READY_TIMEOUT(READY_TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_funct3       (req_funct3),
    .req_csr_addr     (req_csr_addr),
    .req_rs1_data     (req_rs1_data),
    .req_rs1_idx      (req_rs1_idx),
    .csr_read_address (csr_read_address),
    .csr_write_address(csr_write_address),
    .csr_write_data   (csr_write_data),
    .csr_write_enable (csr_write_enable),
    .csr_read_out     (csr_read_out),
    .csr_ready        (csr_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rd_data      (rsp_rd_data),
    .rsp_illegal      (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: ignores writes to read-only space, counts write pulses
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  int          wr_count = 0;
  int          ready_mode;
  logic        rdy_rand = 1'b1;

  always @(posedge clk) begin
    if (pre_we) csr_mem[pre_addr] <= pre_data;
    else if (csr_write_enable && csr_write_address[11:10] != 2'b11)
      csr_mem[csr_write_address] <= csr_write_data;
    if (csr_write_enable) wr_count <= wr_count + 1;
  end

  always @(negedge clk) rdy_rand <= ($urandom_range(0, 3) != 0);

  always_comb begin
    csr_read_out = csr_mem[csr_read_address];
    csr_ready    = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : rdy_rand;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference behaviour from the Zicsr rules; also advances the expected CSR contents
  task automatic refModel(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                          input logic [4:0] idx, input bit stall,
                          output logic exp_ill, output logic [31:0] exp_rd,
                          output int exp_wr, output int exp_lat);
    logic [31:0] old_v, operand, result;
    bit writes;
    old_v   = ref_mem[a];
    operand = f3[2] ? {27'd0, idx} : rs1;
    result  = old_v;
    writes  = 1'b0;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      exp_ill = 1'b1; exp_rd = 32'd0; exp_wr = 0; exp_lat = 1;
    end else if (stall) begin
      exp_ill = 1'b1; exp_rd = 32'd0; exp_wr = 0; exp_lat = 1 + READY_TIMEOUT;
    end else begin
      if (f3 == F3_CSRRW || f3 == F3_CSRRWI) begin
        result = operand; writes = 1'b1;
      end else if (f3 == F3_CSRRS || f3 == F3_CSRRSI) begin
        result = old_v | operand; writes = (idx != 0);
      end else begin
        result = old_v & ~operand; writes = (idx != 0);
      end
      if (writes && RO_CHECK && a[11:10] == 2'b11) begin
        exp_ill = 1'b1; exp_rd = 32'd0; exp_wr = 0; exp_lat = 2;
      end else begin
        exp_ill = 1'b0; exp_rd = old_v; exp_wr = writes ? 1 : 0; exp_lat = writes ? 3 : 2;
        if (writes && a[11:10] != 2'b11) ref_mem[a] = result;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [11:0] a,
                               input logic [31:0] rs1, input logic [4:0] idx,
                               input bit stall, input bit chk_lat);
    logic        exp_ill;
    logic [31:0] exp_rd;
    int          exp_wr, exp_lat, w0, lat, n;
    refModel(f3, a, rs1, idx, stall, exp_ill, exp_rd, exp_wr, exp_lat);
    n = 0;
    while (!req_ready && n < WAIT_LIMIT) begin @(negedge clk); n++; end
    checkOutput({tag, " idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a; req_rs1_data = rs1; req_rs1_idx = idx;
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    checkOutput({tag, " busy"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < WAIT_LIMIT) begin @(negedge clk); lat++; end
    checkOutput({tag, " rsp_seen"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, " illegal"}, 32'(rsp_illegal), 32'(exp_ill));
    checkOutput({tag, " rd"}, rsp_rd_data, exp_rd);
    if (chk_lat) checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    checkOutput({tag, " pulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " ready_after"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " writes"}, 32'(wr_count - w0), 32'(exp_wr));
    checkOutput({tag, " csr_value"}, csr_mem[a], ref_mem[a]);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " write_enable"}, 32'(csr_write_enable), 32'd0);
    checkOutput({tag, " rd_data"}, rsp_rd_data, 32'd0);
    checkOutput({tag, " illegal"}, 32'(rsp_illegal), 32'd0);
    checkOutput({tag, " read_addr"}, 32'(csr_read_address), 32'd0);
    checkOutput({tag, " write_addr"}, 32'(csr_write_address), 32'd0);
    checkOutput({tag, " write_data"}, csr_write_data, 32'd0);
  endtask

  initial begin
    int          w0, seen;
    logic [31:0] keep;
    logic [11:0] addr_list [6];
    addr_list = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MVENDORID, CSR_MCYCLE, CSR_MINSTRET};
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
    req_rs1_data = '0; req_rs1_idx = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    ready_mode = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    preload(CSR_MTVEC, 32'h0000_1000);
    preload(CSR_MEPC, $urandom);
    preload(CSR_MCAUSE, 32'h0000_0004);
    preload(CSR_MVENDORID, 32'h5256_4B43);
    preload(CSR_MCYCLE, $urandom);
    preload(CSR_MINSTRET, $urandom);

    applyStimulus("csrrw_mtvec", F3_CSRRW, CSR_MTVEC, 32'h0000_3000, 5'd7, 1'b0, 1'b1);
    checkOutput("mtvec_written", csr_mem[CSR_MTVEC], 32'h0000_3000);
    applyStimulus("csrrs_mcause_x0", F3_CSRRS, CSR_MCAUSE, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);
    applyStimulus("csrrsi_mtvec", F3_CSRRSI, CSR_MTVEC, 32'h0, 5'h10, 1'b0, 1'b1);
    applyStimulus("csrrci_mtvec", F3_CSRRCI, CSR_MTVEC, 32'h0, 5'h10, 1'b0, 1'b1);
    checkOutput("mtvec_cleared", csr_mem[CSR_MTVEC], 32'h0000_3000);
    applyStimulus("csrrw_mvendorid", F3_CSRRW, CSR_MVENDORID, 32'h0000_3000, 5'd3, 1'b0, 1'b1);
    checkOutput("mvendorid_kept", csr_mem[CSR_MVENDORID], 32'h5256_4B43);
    applyStimulus("funct3_100", 3'b100, CSR_MTVEC, 32'h1234_5678, 5'd1, 1'b0, 1'b1);
    applyStimulus("funct3_000", 3'b000, CSR_MEPC, 32'h1234_5678, 5'd1, 1'b0, 1'b1);

    ready_mode = 1;
    applyStimulus("ready_timeout", F3_CSRRW, CSR_MEPC, 32'hCAFE_0001, 5'd2, 1'b1, 1'b1);
    ready_mode = 0;

    // Kill an access while its write pulse is on the bus
    keep = csr_mem[CSR_MEPC];
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F3_CSRRW; req_csr_addr = CSR_MEPC;
    req_rs1_data = 32'hDEAD_0000 | 32'($urandom_range(1, 255)); req_rs1_idx = 5'd4;
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush pre_write_enable", 32'(csr_write_enable), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush gated_write_enable", 32'(csr_write_enable), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    checkOutput("flush no_rsp", 32'(seen), 32'd0);
    checkOutput("flush no_write", 32'(wr_count - w0), 32'd0);
    checkOutput("flush csr_kept", csr_mem[CSR_MEPC], keep);

    // Request arriving together with flush is dropped
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_funct3 = F3_CSRRW; req_csr_addr = CSR_MTVEC;
    req_rs1_data = 32'h0000_FFFF; req_rs1_idx = 5'd9;
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("drop req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    checkOutput("drop no_rsp", 32'(seen), 32'd0);
    checkOutput("drop no_write", 32'(wr_count - w0), 32'd0);

    // Reset while waiting in READ
    ready_mode = 1;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F3_CSRRW; req_csr_addr = CSR_MEPC;
    req_rs1_data = 32'h0BAD_F00D; req_rs1_idx = 5'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midread busy", 32'(req_ready), 32'd0);
    checkOutput("midread read_addr", 32'(csr_read_address), 32'(CSR_MEPC));
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("midread_reset");
    reset = 1'b0;
    ready_mode = 0;
    @(negedge clk);

    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  idx;
      f3  = 3'($urandom_range(0, 7));
      a   = addr_list[$urandom_range(0, 5)];
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus($sformatf("rand%0d", i), f3, a, $urandom, idx, 1'b0, 1'b0);
    end
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
